// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth sequential multiplier.
// One Booth group of the multiplier is retired per cycle, so a signed
// WIDTH x WIDTH multiply takes WIDTH/2 RUN cycles. The result is written to
// the registered product output on the edge that retires the last group.
// WIDTH must be even and at least 4.

// Radix-4 Booth recoder for one overlapping 3-bit multiplier group.
// o_action[2] = use 1x multiplicand, o_action[1] = use 2x multiplicand,
// o_action[0] = negate the selected value. 000 means a zero partial product.
module booth_encoder (
  input  logic [2:0] i_bits,
  output logic [2:0] o_action
);

  // Map {x2,x1,x0} to the digit in {-2,-1,0,+1,+2}.
  always_comb begin
    // NOTE: default first so that no path through the case leaves o_action unassigned and infers a latch.
    o_action = 3'b000;
    case (i_bits)
      3'b000:  o_action = 3'b000;  //  0
      3'b001:  o_action = 3'b100;  // +1x
      3'b010:  o_action = 3'b100;  // +1x
      3'b011:  o_action = 3'b010;  // +2x
      3'b100:  o_action = 3'b011;  // -2x
      3'b101:  o_action = 3'b101;  // -1x
      3'b110:  o_action = 3'b101;  // -1x
      3'b111:  o_action = 3'b000;  // -0 is encoded as plain zero
      default: o_action = 3'b000;
    endcase
  end

endmodule

module booth_pp_accumulator #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW     = 2 * WIDTH;
  localparam int GROUPS = WIDTH / 2;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [PW-1:0]           r_product;
  logic signed [PW-1:0]    r_acc;
  // Multiplicand, sign-extended to the full product width and pre-shifted by
  // 2 each cycle, so it always carries the 4^i weight of the current group.
  // Full width also keeps -2x of the most negative operand exact.
  logic signed [PW-1:0]    r_mcand;
  logic [WIDTH:0]          r_mplier;
  logic [CNT_W-1:0]        r_count;

  logic [2:0]              w_action;
  logic signed [PW-1:0]    w_mcand_x2;
  logic signed [PW-1:0]    w_sel;
  logic signed [PW-1:0]    w_pp;
  logic signed [PW-1:0]    w_acc_next;
  logic                    w_accept;

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  // A new multiply can only be accepted when not iterating.
  assign w_accept = start && (r_state != ST_RUN);

  booth_encoder u_booth_encoder (
    .i_bits   (r_mplier[2:0]),
    .o_action (w_action)
  );

  assign w_mcand_x2 = {r_mcand[PW-2:0], 1'b0};

  // Select, negate and accumulate the weighted partial product of this group.
  always_comb begin
    w_sel = '0;
    if (w_action[2]) begin
      w_sel = r_mcand;
    end else if (w_action[1]) begin
      w_sel = w_mcand_x2;
    end
    w_pp       = w_action[0] ? -w_sel : w_sel;
    w_acc_next = r_acc + w_pp;
  end

  // Control FSM and datapath registers; every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state, including datapath operands, is cleared here so an aborted multiply leaves nothing behind.
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // NOTE: non-blocking assignments keep every register update in this block sampling pre-edge values.
          r_done <= 1'b0;
          if (w_accept) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_count  <= '0;
            r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            r_mplier <= {b, 1'b0};
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_RUN: begin
          // start is deliberately ignored here.
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[PW-3:0], 2'b00};
          r_mplier <= {{2{r_mplier[WIDTH]}}, r_mplier[WIDTH:2]};
          r_count  <= r_count + CNT_W'(1);
          if (r_count == LAST_GROUP) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_product <= w_acc_next;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator (WIDTH = 16).
// Known vectors from a table, hand-written multi-cycle corner sequences, and
// random operands compared against a plain-arithmetic signed multiply.
module tb_booth_pp_accumulator;

  localparam int W      = 16;
  localparam int GROUPS = W / 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_errors = 0;

  // Last product the bench expects to be on the output; tracked by the bench.
  logic [2*W-1:0] last_exp;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[8];

  booth_pp_accumulator #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed product in wide integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[2*W-1:0];
  endfunction

  // Raise start with operands at the current falling edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
  endtask

  // Called at the falling edge where start was raised. Returns at the falling
  // edge of the DONE cycle, after checking busy/done timing and the product.
  task automatic finish_op(input logic [2*W-1:0] exp, input string name);
    bit run_ok;
    run_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < GROUPS; i++) begin
      if (!(busy === 1'b1 && done === 1'b0 && product === last_exp)) run_ok = 1'b0;
      @(negedge clk);
    end
    check({name, "_run_phase"}, 64'(run_ok), 64'd1);
    check({name, "_done"}, {62'd0, done, busy}, 64'b10);
    check({name, "_product"}, 64'(product), 64'(exp));
    last_exp = exp;
  endtask

  // Move to the cycle after DONE and confirm the pulse lasted one cycle.
  task automatic idle_after(input string name);
    @(negedge clk);
    check({name, "_done_drop"}, {62'd0, done, busy}, 64'b00);
  endtask

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, "v_3x5"};
    vecs[1] = '{16'h8000, 16'h8000, 32'h4000_0000, "v_min_x_min"};
    vecs[2] = '{16'h7FFF, 16'h8000, 32'hC000_8000, "v_max_x_min"};
    vecs[3] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "v_m1_x_1"};
    vecs[4] = '{16'h0000, 16'h1234, 32'h0000_0000, "v_0_x_1234"};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "v_max_x_max"};
    vecs[6] = '{16'hFFF9, 16'h0009, 32'hFFFF_FFC1, "v_m7_x_9"};
    vecs[7] = '{16'h8000, 16'h0001, 32'hFFFF_8000, "v_min_x_1"};

    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    last_exp = '0;

    repeat (2) @(negedge clk);
    check("reset_state", {product, 30'd0, done, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {62'd0, done, busy}, 64'd0);

    // Table-driven vectors, each separated by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b);
      finish_op(vecs[i].exp, vecs[i].name);
      idle_after(vecs[i].name);
    end

    // start during RUN with other operands must be ignored.
    launch(16'h1234, 16'h0567);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 16'h7FFF;
    b     = 16'h7FFF;
    @(negedge clk);
    start = 1'b0;
    repeat (GROUPS - 3) @(negedge clk);
    check("ignore_start_done", {62'd0, done, busy}, 64'b10);
    check("ignore_start_product", 64'(product), 64'(ref_mul(16'h1234, 16'h0567)));
    last_exp = ref_mul(16'h1234, 16'h0567);
    idle_after("ignore_start");

    // Back-to-back: start high in the DONE cycle re-enters RUN directly.
    launch(16'h0003, 16'h0005);
    finish_op(32'h0000_000F, "b2b_first");
    launch(16'hFFF9, 16'h0009);
    finish_op(32'hFFFF_FFC1, "b2b_second");
    idle_after("b2b_second");

    // Asynchronous reset in RUN cycle 4; no done may follow without a new start.
    launch(16'h4321, 16'h0101);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {product, 30'd0, done, busy}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = '0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * GROUPS; i++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      check("no_done_after_reset", 64'(seen), 64'd0);
    end

    // Random operands, randomly chained back-to-back or with an idle gap.
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 16'h8000;
      if ($urandom_range(0, 5) == 0) rb = 16'h8000;
      launch(ra, rb);
      finish_op(ref_mul(ra, rb), $sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) idle_after($sformatf("rand%0d", k));
    end
    idle_after("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
